// File: rtl/alu_result_accumulator.sv
// alu_result_accumulator: rebuilds the full-precision SIMD ALU sum from S and its carries,
// accumulates beats into a wide register, and emits one result per frame over valid/ready.
module alu_result_accumulator #(
    parameter int Width      = 8,
    parameter int AccWidth   = 20,
    parameter int CountWidth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Width-1:0]      S,
    input  logic [1:0]            COUT_W_X_Y_CIN,
    input  logic                  COUT_Z_W_X_Y_CIN,
    input  logic                  in_last,
    input  logic [CountWidth-1:0] acc_len,
    input  logic                  saturate_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AccWidth-1:0]   out_data,
    output logic [CountWidth-1:0] out_count,
    output logic                  out_overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                r_state, w_next;
    logic [AccWidth-1:0]   r_acc, w_acc;
    logic [CountWidth-1:0] r_cnt, w_cnt, r_len, w_len;
    logic                  r_ovf, w_ovf;
    logic [2:0]            w_carry;
    logic [AccWidth:0]     w_ext, w_sum;
    logic [CountWidth-1:0] w_len_eff, w_cnt_inc;
    logic                  w_accept;

    // Both carry outputs weigh 2^Width; their sum (0..4) forms the top three bits of the true sum.
    assign w_carry   = {1'b0, COUT_W_X_Y_CIN} + {2'b00, COUT_Z_W_X_Y_CIN};
    assign w_ext     = (AccWidth+1)'({w_carry, S});
    assign w_sum     = {1'b0, r_acc} + w_ext;
    assign w_len_eff = (acc_len == '0) ? CountWidth'(1) : acc_len;
    assign w_cnt_inc = r_cnt + CountWidth'(1);
    assign in_ready  = !reset && (r_state != HOLD);
    assign w_accept  = in_valid && in_ready;

    assign out_valid    = (r_state == HOLD);
    assign out_data     = r_acc;
    assign out_count    = r_cnt;
    assign out_overflow = r_ovf;

    always_comb begin
        w_next = r_state;
        w_acc  = r_acc;
        w_cnt  = r_cnt;
        w_len  = r_len;
        w_ovf  = r_ovf;
        case (r_state)
            IDLE: if (w_accept) begin
                w_acc  = w_ext[AccWidth-1:0];
                w_cnt  = CountWidth'(1);
                w_len  = w_len_eff;
                w_ovf  = 1'b0;
                w_next = (in_last || w_len_eff == CountWidth'(1)) ? HOLD : ACCUM;
            end
            ACCUM: if (w_accept) begin
                w_acc  = (w_sum[AccWidth] && saturate_en) ? '1 : w_sum[AccWidth-1:0];
                w_cnt  = w_cnt_inc;
                w_ovf  = r_ovf | w_sum[AccWidth];
                w_next = (in_last || w_cnt_inc == r_len) ? HOLD : ACCUM;
            end
            HOLD: w_next = out_ready ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_acc;
            r_cnt   <= w_cnt;
            r_len   <= w_len;
            r_ovf   <= w_ovf;
        end
    end
endmodule
